// File: rtl/bp_me_wormhole_chan_mux_if.sv
// rtl/bp_me_wormhole_chan_mux_if.sv - tile-side and link-side channel bundle for bp_me_wormhole_chan_mux
interface bp_me_wormhole_chan_mux_if #(
   parameter int flit_width_p = 64,
   parameter int chan_p       = 3
);
   logic [chan_p-1:0][flit_width_p-1:0] tx_data_i;
   logic [chan_p-1:0]                   tx_v_i;
   logic [chan_p-1:0]                   tx_ready_and_o;
   logic [flit_width_p-1:0]             link_data_o;
   logic                                link_v_o;
   logic                                link_ready_and_i;
   logic [flit_width_p-1:0]             link_data_i;
   logic                                link_v_i;
   logic                                link_ready_and_o;
   logic [chan_p-1:0][flit_width_p-1:0] rx_data_o;
   logic [chan_p-1:0]                   rx_v_o;
   logic [chan_p-1:0]                   rx_ready_and_i;
   logic                                err_o;

   modport slave (
      input  tx_data_i, tx_v_i, link_ready_and_i, link_data_i, link_v_i, rx_ready_and_i,
      output tx_ready_and_o, link_data_o, link_v_o, link_ready_and_o, rx_data_o, rx_v_o, err_o
   );

   modport master (
      output tx_data_i, tx_v_i, link_ready_and_i, link_data_i, link_v_i, rx_ready_and_i,
      input  tx_ready_and_o, link_data_o, link_v_o, link_ready_and_o, rx_data_o, rx_v_o, err_o
   );
endinterface

// File: rtl/bp_me_wormhole_chan_mux.sv
// rtl/bp_me_wormhole_chan_mux.sv - N-channel wormhole mux/demux onto one link; BP_ME_CHAN_MUX_TAG_CHECK_EN drops illegal-tag packets
module bp_me_wormhole_chan_mux #(
   parameter int flit_width_p  = 64,
   parameter int chan_p        = 3,
   parameter int len_width_p   = 4,
   parameter int len_offset_p  = 0,
   parameter int chan_offset_p = 8
) (
   input logic clk_i,
   input logic reset_n_i,
   bp_me_wormhole_chan_mux_if.slave bus
);
   localparam int chan_width_lp = (chan_p > 1) ? $clog2(chan_p) : 1;

   typedef logic [chan_width_lp-1:0] chan_t;
   typedef logic [len_width_p-1:0]   len_t;
   typedef enum logic {TX_IDLE, TX_BODY} tx_state_e;
   typedef enum logic {RX_IDLE, RX_BODY} rx_state_e;

   tx_state_e               tx_state;
   len_t                    tx_cnt;
   chan_t                   last_grant;
   chan_t                   tx_sel;
   chan_t                   cand;
   logic                    tx_sel_v;
   logic                    tx_can_accept;
   logic                    tx_hs;
   logic [flit_width_p-1:0] tx_flit;
   len_t                    tx_len;
   logic                    link_v_r;
   logic [flit_width_p-1:0] link_data_r;

   // Idle: first valid channel after last_grant wins; body: only the locked channel.
   always_comb begin
      tx_sel   = last_grant;
      tx_sel_v = 1'b0;
      cand     = '0;
      if (tx_state == TX_BODY) begin
         tx_sel_v = bus.tx_v_i[last_grant];
      end else begin
         for (int k = chan_p; k >= 1; k--) begin
            cand = chan_t'((int'(last_grant) + k) % chan_p);
            if (bus.tx_v_i[cand]) begin
               tx_sel   = cand;
               tx_sel_v = 1'b1;
            end
         end
      end
   end

   assign tx_can_accept = !link_v_r || bus.link_ready_and_i;
   assign tx_hs         = reset_n_i && tx_sel_v && tx_can_accept;
   assign tx_flit       = bus.tx_data_i[tx_sel];
   assign tx_len        = tx_flit[len_offset_p +: len_width_p];

   always_comb begin
      bus.tx_ready_and_o = '0;
      for (int i = 0; i < chan_p; i++) begin
         bus.tx_ready_and_o[i] = tx_hs && (tx_sel == chan_t'(i));
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         tx_state    <= TX_IDLE;
         tx_cnt      <= '0;
         last_grant  <= chan_t'(chan_p - 1);
         link_v_r    <= 1'b0;
         link_data_r <= '0;
      end else begin
         if (tx_hs) begin
            link_v_r    <= 1'b1;
            link_data_r <= tx_flit;
         end else if (bus.link_ready_and_i) begin
            link_v_r <= 1'b0;
         end
         if (tx_hs) begin
            if (tx_state == TX_IDLE) begin
               last_grant <= tx_sel;
               tx_cnt     <= tx_len;
               if (tx_len != '0) tx_state <= TX_BODY;
            end else begin
               tx_cnt <= tx_cnt - len_t'(1);
               if (tx_cnt == len_t'(1)) tx_state <= TX_IDLE;
            end
         end
      end
   end

   assign bus.link_v_o    = link_v_r;
   assign bus.link_data_o = link_data_r;

   rx_state_e rx_state;
   len_t      rx_cnt;
   chan_t     rx_route;
   logic      rx_drop;
   chan_t     hdr_tag;
   chan_t     hdr_route;
   logic      hdr_bad;
   len_t      hdr_len;
   chan_t     route_cur;
   logic      drop_cur;
   logic      rx_link_ready;
   logic      rx_hs;

   assign hdr_tag = bus.link_data_i[chan_offset_p +: chan_width_lp];
   assign hdr_len = bus.link_data_i[len_offset_p +: len_width_p];

   always_comb begin
`ifdef BP_ME_CHAN_MUX_TAG_CHECK_EN
      hdr_bad   = (int'(hdr_tag) >= chan_p);
      hdr_route = hdr_bad ? '0 : hdr_tag;
`else
      hdr_bad   = 1'b0;
      hdr_route = chan_t'(int'(hdr_tag) % chan_p);
`endif
   end

   assign route_cur     = (rx_state == RX_IDLE) ? hdr_route : rx_route;
   assign drop_cur      = (rx_state == RX_IDLE) ? hdr_bad : rx_drop;
   assign rx_link_ready = reset_n_i && (drop_cur || bus.rx_ready_and_i[route_cur]);
   assign rx_hs         = bus.link_v_i && rx_link_ready;

   assign bus.link_ready_and_o = rx_link_ready;
   assign bus.rx_data_o        = {chan_p{bus.link_data_i}};

   always_comb begin
      bus.rx_v_o = '0;
      for (int i = 0; i < chan_p; i++) begin
         bus.rx_v_o[i] = reset_n_i && bus.link_v_i && !drop_cur && (route_cur == chan_t'(i));
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_route <= '0;
         rx_drop  <= 1'b0;
      end else if (rx_hs) begin
         if (rx_state == RX_IDLE) begin
            rx_route <= hdr_route;
            rx_drop  <= hdr_bad;
            rx_cnt   <= hdr_len;
            if (hdr_len != '0) rx_state <= RX_BODY;
         end else begin
            rx_cnt <= rx_cnt - len_t'(1);
            if (rx_cnt == len_t'(1)) rx_state <= RX_IDLE;
         end
      end
   end

`ifdef BP_ME_CHAN_MUX_TAG_CHECK_EN
   logic err_r;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         err_r <= 1'b0;
      end else if (rx_hs && (rx_state == RX_IDLE) && hdr_bad) begin
         err_r <= 1'b1;
      end
   end

   assign bus.err_o = err_r;
`else
   assign bus.err_o = 1'b0;
`endif
endmodule

// File: tb/tb_bp_me_wormhole_chan_mux.sv
// tb/tb_bp_me_wormhole_chan_mux.sv - directed bench with packet-level round-robin and steering model
module tb_bp_me_wormhole_chan_mux;
   localparam int FW = 64;
   localparam int CH = 3;
   localparam int LW = 4;
   localparam int LO = 0;
   localparam int CO = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bp_me_wormhole_chan_mux_if #(.flit_width_p(FW), .chan_p(CH)) bus ();

   bp_me_wormhole_chan_mux #(
      .flit_width_p(FW), .chan_p(CH), .len_width_p(LW), .len_offset_p(LO), .chan_offset_p(CO)
   ) dut (
      .clk_i(clk),
      .reset_n_i(rst_n),
      .bus(bus)
   );

   int checks = 0;
   int failures = 0;

   logic [FW-1:0] txq [CH][$];
   logic [FW-1:0] mflits [CH][$];
   int            mlens [CH][$];
   logic [FW-1:0] exp_link [$];
   logic [FW-1:0] rxq [$];
   int            rx_route_q [$];
   bit            rx_hdr_q [$];
   int            model_last = CH - 1;
   bit            exp_err = 1'b0;
   bit            chk_en = 1'b0;
   bit            hold [CH];
   logic [CH-1:0] rx_rdy = '1;
   bit            link_rdy = 1'b1;
   bit            tx_hs [CH];
   bit            rx_hs;
   int            seq = 0;

   task automatic check(string name, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic logic [FW-1:0] mk(int ch, int s, int len, int tag, bit hdr);
      logic [FW-1:0] f;
      f = '0;
      f[63:56] = 8'(ch);
      f[55:40] = 16'(s);
      if (hdr) begin
         f[CO +: 2] = 2'(tag);
         f[LO +: LW] = LW'(len);
      end else begin
         f[LO +: LW] = 4'hA;
      end
      return f;
   endfunction

   task automatic add_tx(int ch, int len);
      logic [FW-1:0] f;
      for (int i = 0; i <= len; i++) begin
         f = mk(ch, seq, len, 0, i == 0);
         seq++;
         txq[ch].push_back(f);
         mflits[ch].push_back(f);
      end
      mlens[ch].push_back(len);
   endtask

   // Packet-level round-robin over everything queued so far.
   task automatic build_expected();
      bit found;
      int c, n;
      found = 1'b1;
      while (found) begin
         found = 1'b0;
         for (int k = 1; k <= CH; k++) begin
            c = (model_last + k) % CH;
            if (!found && mlens[c].size() > 0) begin
               n = mlens[c].pop_front();
               for (int j = 0; j <= n; j++) exp_link.push_back(mflits[c].pop_front());
               model_last = c;
               found = 1'b1;
            end
         end
      end
   endtask

   function automatic int rx_route_of(int tag);
`ifdef BP_ME_CHAN_MUX_TAG_CHECK_EN
      return (tag >= CH) ? -1 : tag;
`else
      return tag % CH;
`endif
   endfunction

   task automatic add_rx(int tag, int len);
      int r;
      r = rx_route_of(tag);
      for (int i = 0; i <= len; i++) begin
         rxq.push_back(mk(9, seq, len, tag, i == 0));
         seq++;
         rx_route_q.push_back(r);
         rx_hdr_q.push_back(i == 0);
      end
   endtask

   task automatic drive_inputs();
      for (int c = 0; c < CH; c++) begin
         bus.tx_v_i[c]    = (txq[c].size() > 0) && !hold[c];
         bus.tx_data_i[c] = (txq[c].size() > 0) ? txq[c][0] : '0;
      end
      bus.link_ready_and_i = link_rdy;
      bus.link_v_i         = rxq.size() > 0;
      bus.link_data_i      = (rxq.size() > 0) ? rxq[0] : '0;
      bus.rx_ready_and_i   = rx_rdy;
   endtask

   task automatic capture();
      for (int c = 0; c < CH; c++) tx_hs[c] = bus.tx_v_i[c] && bus.tx_ready_and_o[c];
      rx_hs = bus.link_v_i && bus.link_ready_and_o;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      for (int c = 0; c < CH; c++) if (tx_hs[c]) void'(txq[c].pop_front());
      if (rx_hs) begin
         if (rx_hdr_q[0] && rx_route_q[0] < 0) exp_err = 1'b1;
         void'(rxq.pop_front());
         void'(rx_route_q.pop_front());
         void'(rx_hdr_q.pop_front());
      end
      drive_inputs();
      @(negedge clk);
      capture();
   endtask

   task automatic drain(string name, int maxc);
      int n;
      n = 0;
      while ((exp_link.size() > 0 || rxq.size() > 0) && n < maxc) begin
         step();
         n++;
      end
      if (exp_link.size() > 0 || rxq.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout link_left=%0d rx_left=%0d required=0", name, exp_link.size(), rxq.size());
      end
   endtask

   logic [FW-1:0] prev_data;
   bit            prev_stall = 1'b0;
   int            r;

   always @(negedge clk) begin
      if (!rst_n || !chk_en) begin
         prev_stall = 1'b0;
      end else begin
         if (bus.link_v_o && bus.link_ready_and_i) begin
            if (exp_link.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL link_extra actual=%h required=none", bus.link_data_o);
            end else begin
               check("link_data", bus.link_data_o, exp_link.pop_front());
            end
         end
         if (prev_stall) begin
            check("stall_v", 64'(bus.link_v_o), 64'(1));
            check("stall_data", bus.link_data_o, prev_data);
         end
         if (bus.link_v_o && !bus.link_ready_and_i) check("stall_tx_ready", 64'(bus.tx_ready_and_o), 64'(0));
         prev_stall = bus.link_v_o && !bus.link_ready_and_i;
         prev_data  = bus.link_data_o;
         if (bus.link_v_i && rx_route_q.size() > 0) begin
            r = rx_route_q[0];
            if (r < 0) begin
               check("rx_v_drop", 64'(bus.rx_v_o), 64'(0));
               check("rx_rdy_drop", 64'(bus.link_ready_and_o), 64'(1));
            end else begin
               check("rx_v", 64'(bus.rx_v_o), 64'(1) << r);
               check("rx_rdy", 64'(bus.link_ready_and_o), 64'(bus.rx_ready_and_i[r]));
               check("rx_data", bus.rx_data_o[r], bus.link_data_i);
            end
         end else begin
            check("rx_v_idle", 64'(bus.rx_v_o), 64'(0));
         end
         check("err", 64'(bus.err_o), 64'(exp_err));
      end
   end

   initial begin
      for (int c = 0; c < CH; c++) hold[c] = 1'b0;
      for (int k = 0; k < 3; k++) for (int c = 0; c < CH; c++) add_tx(c, 0);
      add_rx(2, 2);
      build_expected();
      check("pin_rr0", 64'(exp_link[0][63:56]), 64'(0));
      check("pin_rr1", 64'(exp_link[1][63:56]), 64'(1));
      check("pin_rr3", 64'(exp_link[3][63:56]), 64'(0));
      check("pin_rx_tag2", 64'(rx_route_q[0]), 64'(2));
      drive_inputs();

      // Reset state with all inputs valid.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_link_v", 64'(bus.link_v_o), 64'(0));
      check("rst_link_data", bus.link_data_o, 64'(0));
      check("rst_tx_ready", 64'(bus.tx_ready_and_o), 64'(0));
      check("rst_rx_v", 64'(bus.rx_v_o), 64'(0));
      check("rst_link_ready", 64'(bus.link_ready_and_o), 64'(0));
      check("rst_err", 64'(bus.err_o), 64'(0));
      #2;
      rst_n = 1'b1;
      chk_en = 1'b1;
      #1;
      capture();

      // Single-flit packets on every channel: 0,1,2,0,1,2... at one flit per cycle.
      for (int k = 0; k < 9; k++) begin
         step();
         check("t1_v", 64'(bus.link_v_o), 64'(1));
         check("t1_chan", 64'(bus.link_data_o[63:56]), 64'(k % 3));
      end
      drain("t1", 50);

      // Multi-flit packet on channel 1 stays contiguous ahead of channel 2.
      add_tx(1, 3);
      add_tx(2, 0);
      build_expected();
      for (int k = 0; k < 4; k++) check("pin_t2_ch1", 64'(exp_link[k][63:56]), 64'(1));
      check("pin_t2_ch2", 64'(exp_link[4][63:56]), 64'(2));
      drain("t2", 50);

      // Link stall mid-packet, then locked channel drops valid.
      add_tx(0, 4);
      add_tx(1, 0);
      build_expected();
      check("pin_t3_first", 64'(exp_link[0][63:56]), 64'(0));
      check("pin_t3_last", 64'(exp_link[5][63:56]), 64'(1));
      repeat (2) step();
      link_rdy = 1'b0;
      repeat (5) step();
      link_rdy = 1'b1;
      hold[0] = 1'b1;
      step();
      step();
      check("t3_lock_ch1_ready", 64'(bus.tx_ready_and_o[1]), 64'(0));
      hold[0] = 1'b0;
      drain("t3", 50);

      // Receive steering with per-channel backpressure and an out-of-range tag.
      rx_rdy = 3'b101;
      add_rx(1, 1);
      add_rx(3, 1);
      add_rx(0, 0);
      check("pin_rx_tag1", 64'(rx_route_q[0]), 64'(1));
`ifdef BP_ME_CHAN_MUX_TAG_CHECK_EN
      check("pin_rx_tag3", 64'(rx_route_q[2]), 64'(-1));
`else
      check("pin_rx_tag3", 64'(rx_route_q[2]), 64'(0));
`endif
      repeat (2) step();
      rx_rdy = '1;
      drain("t4", 50);
`ifdef BP_ME_CHAN_MUX_TAG_CHECK_EN
      check("t4_err_sticky", 64'(bus.err_o), 64'(1));
`else
      check("t4_err_tied", 64'(bus.err_o), 64'(0));
`endif

      // Reset during a 4-flit packet; arbitration restarts at channel 0.
      add_tx(1, 3);
      build_expected();
      repeat (2) step();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      chk_en = 1'b0;
      #1;
      check("t5_link_v_abort", 64'(bus.link_v_o), 64'(0));
      for (int c = 0; c < CH; c++) begin
         txq[c].delete();
         mflits[c].delete();
         mlens[c].delete();
         tx_hs[c] = 1'b0;
      end
      exp_link.delete();
      exp_err = 1'b0;
      model_last = CH - 1;
      add_tx(2, 0);
      add_tx(0, 0);
      build_expected();
      check("pin_t5_first", 64'(exp_link[0][63:56]), 64'(0));
      drive_inputs();
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      chk_en = 1'b1;
      #1;
      capture();
      step();
      check("t5_first_v", 64'(bus.link_v_o), 64'(1));
      check("t5_first_chan", 64'(bus.link_data_o[63:56]), 64'(0));
      drain("t5", 50);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
